// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter input conditioner.
// Holds the legal synchronizer depth range and the filter counter width rule.
package sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;

    // Counter must hold 0..n, and a zero-width vector is never legal.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel of sync_filter: N-stage synchronizer, optional stable-for-N glitch
// filter and registered-level edge detection producing one-cycle rise/fall pulses.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RESET_VAL     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    input  logic sample_en,
    output logic dout,
    output logic rise,
    output logic fall
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_badStages
        $error("sync_filter_chan: STAGES=%0d outside legal range %0d..%0d",
               STAGES, STAGES_MIN, STAGES_MAX);
    end

    if (FILTER_CYCLES < 0) begin : g_badFilter
        $error("sync_filter_chan: FILTER_CYCLES=%0d must not be negative", FILTER_CYCLES);
    end

    logic [STAGES-1:0] r_sync;
    logic              w_syncOut;
    logic              w_dout;
    logic              r_doutPrev;

    // Plain shift chain; din only ever lands in a flop, never in logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
        end
    end

    assign w_syncOut = r_sync[STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_bypass
        logic w_unusedSampleEn;

        assign w_unusedSampleEn = sample_en;
        assign w_dout           = w_syncOut;
    end else begin : g_filter
        localparam int             CW   = cnt_width(FILTER_CYCLES);
        localparam logic [CW-1:0]  LAST = CW'(FILTER_CYCLES - 1);

        logic [CW-1:0] r_count;
        logic          r_dout;

        // Any sample matching the accepted level aborts a pending change, even
        // between sample_en ticks; only qualified mismatches advance the count.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_count <= '0;
                r_dout  <= RESET_VAL;
            end else if (w_syncOut == r_dout) begin
                r_count <= '0;
            end else if (sample_en) begin
                if (r_count == LAST) begin
                    r_dout  <= w_syncOut;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end

        assign w_dout = r_dout;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_doutPrev <= RESET_VAL;
        end else begin
            r_doutPrev <= w_dout;
        end
    end

    assign dout = w_dout;
    assign rise = w_dout & ~r_doutPrev;
    assign fall = ~w_dout & r_doutPrev;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input conditioner for asynchronous pins: one independent
// sync_filter_chan per bit plus a combined any_edge strobe.
module sync_filter
    import sync_pkg::*;
#(
    parameter int   WIDTH         = 1,
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RESET_VAL     = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             sample_en,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .STAGES       (STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_VAL    (RESET_VAL)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .din      (din[i]),
            .sample_en(sample_en),
            .dout     (dout[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: four differently parameterised instances
// share one clock/reset; expected outputs are queued with a cycle stamp and checked.
module tb_sync_filter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // A: legacy 2-FF idle-high, B: 4-wide S=3 F=4, C: S=2 F=3 gated, D: S=2 F=8 idle-high
    logic [0:0] dinA = 1'b1;
    logic [0:0] doutA, riseA, fallA;
    logic       anyA;
    logic [3:0] dinB = 4'b0000;
    logic [3:0] doutB, riseB, fallB;
    logic       anyB;
    logic       seB = 1'b1;
    logic [0:0] dinC = 1'b0;
    logic [0:0] doutC, riseC, fallC;
    logic       anyC;
    logic       seC = 1'b0;
    logic [0:0] dinD = 1'b1;
    logic [0:0] doutD, riseD, fallD;
    logic       anyD;
    logic       seD = 1'b1;

    always #5 clock = ~clock;

    sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(0), .RESET_VAL(1'b1)) dutA (
        .clock(clock), .reset(reset), .din(dinA), .sample_en(1'b0),
        .dout(doutA), .rise(riseA), .fall(fallA), .any_edge(anyA));

    sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(1'b0)) dutB (
        .clock(clock), .reset(reset), .din(dinB), .sample_en(seB),
        .dout(doutB), .rise(riseB), .fall(fallB), .any_edge(anyB));

    sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(1'b0)) dutC (
        .clock(clock), .reset(reset), .din(dinC), .sample_en(seC),
        .dout(doutC), .rise(riseC), .fall(fallC), .any_edge(anyC));

    sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(8), .RESET_VAL(1'b1)) dutD (
        .clock(clock), .reset(reset), .din(dinD), .sample_en(seD),
        .dout(doutD), .rise(riseD), .fall(fallD), .any_edge(anyD));

    typedef struct {
        int          stamp;
        int          id;
        logic [12:0] exp;
    } entry_t;

    entry_t sb[$];
    string  dutName[4] = '{"A", "B", "C", "D"};

    function automatic logic [12:0] packOut(logic [3:0] d, logic [3:0] r, logic [3:0] f, logic a);
        return {d, r, f, a};
    endfunction

    function automatic logic [12:0] obsOf(int id);
        case (id)
            0:       return packOut({3'b000, doutA}, {3'b000, riseA}, {3'b000, fallA}, anyA);
            1:       return packOut(doutB, riseB, fallB, anyB);
            2:       return packOut({3'b000, doutC}, {3'b000, riseC}, {3'b000, fallC}, anyC);
            default: return packOut({3'b000, doutD}, {3'b000, riseD}, {3'b000, fallD}, anyD);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [12:0] observed, input logic [12:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed dout/rise/fall/any=%b required=%b", tag, observed, expected);
        end
    endtask

    task automatic expectAt(input int stamp, input int id, input logic [3:0] d,
                            input logic [3:0] r, input logic [3:0] f);
        entry_t e;
        e.stamp = stamp;
        e.id    = id;
        e.exp   = packOut(d, r, f, |(r | f));
        sb.push_back(e);
    endtask

    // Level change driven at cycle c: old level just before, one pulse, then quiet.
    task automatic expectStep(input int id, input int c, input int lat,
                              input logic [3:0] oldV, input logic [3:0] newV);
        expectAt(c + lat - 1, id, oldV, 4'b0000, 4'b0000);
        expectAt(c + lat,     id, newV, newV & ~oldV, ~newV & oldV);
        expectAt(c + lat + 1, id, newV, 4'b0000, 4'b0000);
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(posedge clock) begin
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            entry_t e;
            e = sb.pop_front();
            checkOutput($sformatf("%s@%0d", dutName[e.id], e.stamp), obsOf(e.id), e.exp);
        end
    end

    initial begin
        int c;
        int guard;

        applyStimulus(3);
        checkOutput("rst.A", obsOf(0), packOut(4'b0001, 4'b0000, 4'b0000, 1'b0));
        checkOutput("rst.B", obsOf(1), packOut(4'b0000, 4'b0000, 4'b0000, 1'b0));
        checkOutput("rst.C", obsOf(2), packOut(4'b0000, 4'b0000, 4'b0000, 1'b0));
        checkOutput("rst.D", obsOf(3), packOut(4'b0001, 4'b0000, 4'b0000, 1'b0));

        reset = 1'b0;
        c = cyc;
        expectAt(c + 1, 0, 4'b0001, 4'b0000, 4'b0000);
        expectAt(c + 1, 1, 4'b0000, 4'b0000, 4'b0000);
        expectAt(c + 1, 2, 4'b0000, 4'b0000, 4'b0000);
        expectAt(c + 1, 3, 4'b0001, 4'b0000, 4'b0000);
        applyStimulus(3);

        c = cyc;
        dinA = 1'b0;
        expectStep(0, c, 2, 4'b0001, 4'b0000);
        applyStimulus(5);

        c = cyc;
        dinB = 4'b0001;
        expectStep(1, c, 7, 4'b0000, 4'b0001);
        applyStimulus(10);
        c = cyc;
        dinB = 4'b0000;
        expectStep(1, c, 7, 4'b0001, 4'b0000);
        applyStimulus(10);

        c = cyc;
        for (int k = 1; k <= 12; k++) expectAt(c + k, 1, 4'b0000, 4'b0000, 4'b0000);
        dinB = 4'b0010;
        applyStimulus(3);
        dinB = 4'b0000;
        applyStimulus(10);

        c = cyc;
        for (int k = 1; k <= 6; k++) expectAt(c + k, 1, 4'b0000, 4'b0000, 4'b0000);
        expectStep(1, c, 7, 4'b0000, 4'b0010);
        for (int k = 9; k <= 10; k++) expectAt(c + k, 1, 4'b0010, 4'b0000, 4'b0000);
        expectStep(1, c + 4, 7, 4'b0010, 4'b0000);
        dinB = 4'b0010;
        applyStimulus(4);
        dinB = 4'b0000;
        applyStimulus(12);

        c = cyc;
        dinB = 4'b0101;
        expectStep(1, c, 7, 4'b0000, 4'b0101);
        applyStimulus(10);
        c = cyc;
        dinB = 4'b0100;
        expectStep(1, c, 7, 4'b0101, 4'b0100);
        applyStimulus(10);

        c = cyc;
        for (int k = 1; k <= 11; k++) expectAt(c + k, 2, 4'b0000, 4'b0000, 4'b0000);
        expectAt(c + 12, 2, 4'b0001, 4'b0001, 4'b0000);
        expectAt(c + 13, 2, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 0; k < 16; k++) begin
            seC = (k % 4 == 3);
            if (k == 0) dinC = 1'b1;
            applyStimulus(1);
        end
        seC = 1'b0;
        dinC = 1'b0;
        c = cyc;
        for (int k = 1; k <= 20; k++) expectAt(c + k, 2, 4'b0001, 4'b0000, 4'b0000);
        applyStimulus(21);

        c = cyc;
        dinD = 1'b0;
        for (int k = 1; k <= 7; k++) expectAt(c + k, 3, 4'b0001, 4'b0000, 4'b0000);
        applyStimulus(7);
        reset = 1'b1;
        #1;
        checkOutput("midrst.D", obsOf(3), packOut(4'b0001, 4'b0000, 4'b0000, 1'b0));
        checkOutput("midrst.A", obsOf(0), packOut(4'b0001, 4'b0000, 4'b0000, 1'b0));
        applyStimulus(2);
        reset = 1'b0;
        c = cyc;
        for (int k = 1; k <= 8; k++) expectAt(c + k, 3, 4'b0001, 4'b0000, 4'b0000);
        expectStep(3, c, 10, 4'b0001, 4'b0000);

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            applyStimulus(1);
            guard++;
        end
        if (sb.size() > 0) begin
            checkOutput("scoreboard.drain", 13'(sb.size()), 13'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Parametrised multi-bit input conditioner for asynchronous pins such as UART RX lines, buttons and external strobes.
- Per-channel N-stage flip-flop synchronizer, then an optional digital glitch filter (stable-for-N-samples), then registered rise/fall edge pulses.
- Sits directly behind top-level pins, ahead of UART receivers and other consumers.
- With WIDTH=1, STAGES=2, FILTER_CYCLES=0, RESET_VAL=1, dout is cycle-identical to a plain 2-FF idle-high synchronizer.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchronizer depth. Legal values are 2 to 4; any other value is an elaboration error.
- FILTER_CYCLES, 0, number of consecutive qualifying samples a new level must hold before dout accepts it. 0 means the filter is bypassed.
- RESET_VAL, 1, reset and idle level, applied to all channels. 1 suits an idle-high UART line.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: reset, asynchronous, active-high.
- din, input, WIDTH: asynchronous raw inputs.
- sample_en, input, 1: filter sample qualifier, for example a prescaler tick. Tie to 1 to sample every clock. Ignored when FILTER_CYCLES=0.
- dout, output, WIDTH: synchronized, filtered levels.
- rise, output, WIDTH: one-cycle pulse when dout[i] goes 0 to 1.
- fall, output, WIDTH: one-cycle pulse when dout[i] goes 1 to 0.
- any_edge, output, 1: OR of all rise and fall bits.

Behaviour:
- Reset (asynchronous): every sync stage, dout, dout_prev and filter counter are forced as follows.
  - Sync stages, dout and dout_prev go to RESET_VAL; counters go to 0.
  - rise, fall and any_edge are therefore 0 during reset and on the first cycle after release.
  - Reset asserted mid-filter discards the partial count. Nothing is remembered across reset.
- Sync chain: s[0] <= din, s[k] <= s[k-1] on each clock. sync_out = s[STAGES-1]. No combinational path from din.
- Filter bypass (FILTER_CYCLES=0): dout = sync_out directly, with no extra register. No counter is instantiated.
- Filter (FILTER_CYCLES>=1), per channel, counter width $clog2(FILTER_CYCLES+1):
  - sync_out == dout: count <= 0. This holds regardless of sample_en, so any return to the current level aborts the pending change.
  - Mismatch, sample_en=0: count holds.
  - Mismatch, sample_en=1, count < FILTER_CYCLES-1: count <= count+1.
  - Mismatch, sample_en=1, count == FILTER_CYCLES-1: dout <= sync_out, count <= 0.
- Latency with sample_en=1 and din stable from before rising edge E0:
  - dout shows the new value after edge E0+STAGES+FILTER_CYCLES-1.
  - That is STAGES+FILTER_CYCLES rising edges in total.
- Glitch rejection: a din pulse that is at most FILTER_CYCLES-1 clocks wide (with sample_en=1) never reaches dout.
- Edges: dout_prev <= dout every clock.
  - rise = dout & ~dout_prev.
  - fall = ~dout & dout_prev.
  - Each pulse is high for exactly one cycle, the first cycle dout shows the new level.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses, and any_edge is a single 1.
- The counter never exceeds FILTER_CYCLES-1. No wrap-around is possible.

Decomposition:
- Package sync_pkg holds:
  - the STAGES_MIN=2 and STAGES_MAX=4 constants;
  - a cnt_width(n) function returning $clog2(n+1), with minimum 1.
- Sub-module sync_filter_chan: one channel containing the sync chain, filter counter and edge detect.
- sync_filter is a generate loop over WIDTH instances plus the any_edge OR reduction.

Test Plan:
- Legacy equivalence (W=1, S=2, F=0, RV=1):
  - Release reset with din=1 -> dout=1, no fall pulse.
  - din goes to 0 before edge 0 -> dout=0 after edge 1, fall=1 for exactly that cycle.
- Latency (S=3, F=4, sample_en=1): din goes 0 to 1 before edge 0 -> dout rises after edge 6, rise pulses once, any_edge=1 the same cycle.
- Glitch rejection (S=2, F=4): din high for 3 clocks then low -> dout stays 0, no rise, counter returns to 0.
  - Then din high for 4 clocks -> dout goes 1 for a single transition.
- sample_en gating (F=3, sample_en=1 every 4th cycle): din steps to 1 -> dout changes only on the 3rd qualifying tick after mismatch.
  - Steady sample_en=0 -> dout never changes.
- Multi-channel (W=4, RV=0): din=4'b0101 simultaneously -> dout=0101 on the same cycle, rise=0101, fall=0000, any_edge=1.
  - Then din=0100 -> only fall[0] pulses.
- Reset mid-operation (F=8): assert reset when count=5 with din=0 and dout=1 -> dout=1 immediately and all counters 0.
  - After release with din=0 -> a full 8 samples plus STAGES are needed before fall.
